// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SEC Hamming(38,32) constants, position map and parity coverage masks.
package ecc_pkg;
    localparam int DATA_W = 32;
    localparam int CODE_W = 38;
    localparam int SYN_W = 6;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;
    typedef logic [SYN_W-1:0] syn_t;
    typedef logic [DATA_W-1:0][5:0] pos_map_t;
    typedef logic [SYN_W-1:0][CODE_W-1:0] cov_t;

    function automatic pos_map_t build_pos();
        pos_map_t m;
        int n;
        m = '0;
        n = 0;
        for (int p = 1; p <= CODE_W; p++)
            if ((p & (p - 1)) != 0) begin
                m[n] = 6'(p);
                n++;
            end
        return m;
    endfunction

    // Data-only coverage; P2 deliberately leaves out D0 (position 3) to match the encoder.
    function automatic cov_t build_cov();
        cov_t c;
        c = '0;
        for (int k = 0; k < SYN_W; k++)
            for (int p = 1; p <= CODE_W; p++)
                if ((p & (p - 1)) != 0 && ((p >> k) & 1) == 1 && !(k == 1 && p == 3))
                    c[k][p-1] = 1'b1;
        return c;
    endfunction

    localparam pos_map_t DATA_POS = build_pos();
    localparam cov_t COV_MASK = build_cov();

    function automatic data_t extract_data(input code_t c);
        data_t d;
        for (int i = 0; i < DATA_W; i++) d[i] = c[DATA_POS[i] - 6'd1];
        return d;
    endfunction
endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational syndrome {S32..S1} of a received codeword.
module ecc_syndrome
    import ecc_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SYN_W-1:0]  syn
);
    for (genvar k = 0; k < SYN_W; k++) begin : g_s
        assign syn[k] = code[(1 << k) - 1] ^ (^(code & COV_MASK[k]));
    end
endmodule

// File: rtl/ecc_decoder.sv
// ecc_decoder: two-stage pipelined SEC decoder with ready/valid flow control and
// saturating corrected/uncorrectable event counters.
module ecc_decoder
    import ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome_out,
    output logic              err_corrected,
    output logic              err_uncorr,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);
    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic [SYN_W-1:0]  s1_syn;
    logic [SYN_W-1:0]  syn;
    logic              ld1;
    logic              ld2;
    logic              fixable;
    logic [CODE_W-1:0] fixed;
    logic              hs;

    ecc_syndrome u_syn (
        .code(data_in),
        .syn (syn)
    );

    assign ld2 = !out_valid || out_ready;
    assign ld1 = !s1_valid || ld2;
    assign in_ready = ld1;
    assign hs = out_valid && out_ready;

    // Flipping bit s-1 for a power-of-two syndrome only touches a parity bit, so data is unchanged.
    always_comb begin
        fixable = (s1_syn != '0) && (s1_syn <= 6'd38);
        fixed = s1_code ^ (fixable ? (CODE_W'(1) << (s1_syn - 6'd1)) : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code <= '0;
            s1_syn <= '0;
        end else if (ld1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= data_in;
                s1_syn <= syn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out <= '0;
            syndrome_out <= '0;
            err_corrected <= 1'b0;
            err_uncorr <= 1'b0;
        end else if (ld2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= extract_data(fixed);
                syndrome_out <= s1_syn;
                err_corrected <= fixable;
                err_uncorr <= s1_syn > 6'd38;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            corr_count <= '0;
            uncorr_count <= '0;
        end else if (hs) begin
            if (err_corrected && !(&corr_count)) corr_count <= corr_count + CNT_W'(1);
            if (err_uncorr && !(&uncorr_count)) uncorr_count <= uncorr_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ecc_decoder.sv
// tb_ecc_decoder: directed vector table plus stall, clear and reset sequences for ecc_decoder.
module tb_ecc_decoder;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [37:0]   data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   data_out;
    logic [5:0]    syndrome_out;
    logic          err_corrected;
    logic          err_uncorr;
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] corr_count;
    logic [CW-1:0] uncorr_count;

    ecc_decoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .syndrome_out(syndrome_out), .err_corrected(err_corrected), .err_uncorr(err_uncorr),
        .cnt_clear(cnt_clear), .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [37:0] din;
        logic [31:0] dout;
        logic [5:0]  syn;
        logic        corr;
        logic        unc;
    } vec_t;

    vec_t tv[13];
    int exp_corr = 0;
    int exp_unc = 0;
    logic [5:0] ws[5];
    logic [37:0] one = 38'd1;
    int sent;
    int recv;
    logic seen;

    initial begin
        tv[0]  = '{38'h3F7FFFFFF6, 32'hFFFFFFFF, 6'd0,  1'b0, 1'b0};
        tv[1]  = '{38'h0000000400, 32'h00000000, 6'd11, 1'b1, 1'b0};
        tv[2]  = '{38'h0080000040, 32'h00000008, 6'd39, 1'b0, 1'b1};
        tv[3]  = '{38'h0000000004, 32'h00000001, 6'd1,  1'b1, 1'b0};
        tv[4]  = '{38'h0000000000, 32'h00000000, 6'd0,  1'b0, 1'b0};
        tv[5]  = '{38'h1F7FFFFFF6, 32'hFFFFFFFF, 6'd38, 1'b1, 1'b0};
        tv[6]  = '{38'h3F7FFFFFF7, 32'hFFFFFFFF, 6'd1,  1'b1, 1'b0};
        tv[7]  = '{38'h0000000003, 32'h00000001, 6'd3,  1'b1, 1'b0};
        tv[8]  = '{38'h2000000001, 32'h80000000, 6'd39, 1'b0, 1'b1};
        tv[9]  = '{38'h0100000000, 32'h00000000, 6'd33, 1'b1, 1'b0};
        tv[10] = '{38'h00C0000000, 32'h02000000, 6'd63, 1'b0, 1'b1};
        tv[11] = '{38'h0000008000, 32'h00000000, 6'd16, 1'b1, 1'b0};
        tv[12] = '{38'h3F7FFF7FF6, 32'hFFFFFFFF, 6'd16, 1'b1, 1'b0};
        ws[0] = 6'd5; ws[1] = 6'd6; ws[2] = 6'd7; ws[3] = 6'd9; ws[4] = 6'd10;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_syndrome", 64'(syndrome_out), 64'd0);
        chk("rst_flags", 64'({err_corrected, err_uncorr}), 64'd0);
        chk("rst_counts", 64'({corr_count, uncorr_count}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in = tv[i].din;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_latency", i), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("v%0d_data", i), 64'(data_out), 64'(tv[i].dout));
            chk($sformatf("v%0d_syn", i), 64'(syndrome_out), 64'(tv[i].syn));
            chk($sformatf("v%0d_flags", i), 64'({err_corrected, err_uncorr}), 64'({tv[i].corr, tv[i].unc}));
            if (tv[i].corr && exp_corr < 7) exp_corr++;
            if (tv[i].unc && exp_unc < 7) exp_unc++;
            @(negedge clk);
            chk($sformatf("v%0d_corr_cnt", i), 64'(corr_count), 64'(exp_corr));
            chk($sformatf("v%0d_unc_cnt", i), 64'(uncorr_count), 64'(exp_unc));
        end

        // Stall: sink blocked for 3 cycles, clear lands on the first corrected handshake.
        sent = 0;
        recv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            out_ready = (c >= 3);
            cnt_clear = (c == 3);
            in_valid = (sent < 5);
            if (sent < 5) data_in = one << (ws[sent] - 6'd1);
            else data_in = '0;
            #1;
            if (c == 2) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_hold_syn", 64'(syndrome_out), 64'd5);
            end
            if (c == 4) chk("clear_wins", 64'(corr_count), 64'd0);
            if (out_valid && out_ready && recv < 5) begin
                chk($sformatf("order%0d_syn", recv), 64'(syndrome_out), 64'(ws[recv]));
                chk($sformatf("order%0d_data", recv), 64'(data_out), 64'd0);
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        cnt_clear = 1'b0;
        chk("stream_sent", 64'(sent), 64'd5);
        chk("stream_recv", 64'(recv), 64'd5);
        chk("stream_corr_cnt", 64'(corr_count), 64'd4);
        chk("stream_unc_cnt", 64'(uncorr_count), 64'd0);

        // Reset with two words in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in = 38'h0000000400;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_counts", 64'({corr_count, uncorr_count}), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_emit", 64'(seen), 64'd0);
        chk("midrst_counts_after", 64'({corr_count, uncorr_count}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
